// File: rtl/spi_cmd_framer_pkg.sv
// Shared definitions for the SPI command framer and the command executor:
// FSM encoding, frame geometry, start pattern and CRC7 polynomial.
package spi_cmd_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    localparam int          FRAME_BYTES   = 6;
    localparam logic [1:0]  START_PATTERN = 2'b01;
    localparam logic [6:0]  CRC7_POLY     = 7'h09;

    // Count value held while waiting for the final (CRC + end bit) byte.
    localparam logic [2:0]  LAST_COUNT    = 3'(FRAME_BYTES - 1);

endpackage

// File: rtl/spi_cmd_framer_crc7.sv
// Combinational CRC7 (x^7 + x^3 + 1) advance over one full byte, MSB first,
// unrolled into eight single-bit steps.
module crc7_byte
    import spi_cmd_framer_pkg::*;
(
    input  logic [6:0] i_crc,
    input  logic [7:0] i_byte,
    output logic [6:0] o_crc
);

    logic [6:0] w_crc;
    logic       w_fb;

    // NOTE: every variable written in this always_comb gets a value before any
    // branch or loop, so no path can leave it holding state (no latch).
    always_comb begin
        w_crc = i_crc;
        w_fb  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            w_fb  = w_crc[6] ^ i_byte[i];
            w_crc = {w_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/spi_cmd_framer.sv
// Assembles 6-byte SD-style command frames from the SPI byte stream, checks
// CRC7 and end bit, and presents each command on a valid/ready handshake.
module spi_cmd_framer
    import spi_cmd_framer_pkg::*;
#(
    parameter bit         CRC_CHECK = 1'b1,
    parameter logic [7:0] FILL_BYTE = 8'hFF
)
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CS,
    input  logic [7:0]  Buffer,
    input  logic        Changed,
    output logic        CmdValid,
    input  logic        CmdReady,
    output logic [5:0]  CmdIndex,
    output logic [31:0] CmdArg,
    output logic        CrcOk,
    output logic        Overrun
);

    state_e      r_state;
    logic [2:0]  r_count;
    logic [6:0]  r_crc;
    logic [5:0]  r_index;
    logic [31:0] r_arg;
    logic        r_cmd_valid;
    logic [5:0]  r_cmd_index;
    logic [31:0] r_cmd_arg;
    logic        r_crc_ok;
    logic        r_overrun;

    logic        w_byte_evt;
    logic        w_is_start;
    logic        w_accept;
    logic        w_crc_pass;
    logic [6:0]  w_crc_seed;
    logic [6:0]  w_crc_next;

    // Chip select wins over a coincident byte strobe.
    assign w_byte_evt = Changed && !CS;
    assign w_is_start = (Buffer[7:6] == START_PATTERN) && (Buffer != FILL_BYTE);
    assign w_accept   = r_cmd_valid && CmdReady;
    assign w_crc_pass = (Buffer[7:1] == r_crc) || !CRC_CHECK;

    // A new frame always starts the CRC from zero, whatever is left in r_crc.
    assign w_crc_seed = (r_state == ST_IDLE) ? 7'h00 : r_crc;

    crc7_byte u_crc7 (
        .i_crc  (w_crc_seed),
        .i_byte (Buffer),
        .o_crc  (w_crc_next)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_count     <= 3'd0;
            r_crc       <= 7'h00;
            r_index     <= 6'd0;
            r_arg       <= 32'h0;
            r_cmd_valid <= 1'b0;
            r_cmd_index <= 6'd0;
            r_cmd_arg   <= 32'h0;
            r_crc_ok    <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_byte_evt && w_is_start) begin
                        r_index <= Buffer[5:0];
                        r_crc   <= w_crc_next;
                        r_count <= 3'd1;
                        r_state <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (CS) begin
                        r_count <= 3'd0;
                        r_state <= ST_IDLE;
                    end else if (Changed) begin
                        if (r_count == LAST_COUNT) begin
                            r_cmd_index <= r_index;
                            r_cmd_arg   <= r_arg;
                            r_crc_ok    <= w_crc_pass && Buffer[0];
                            r_cmd_valid <= 1'b1;
                            r_count     <= 3'd0;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_arg   <= {r_arg[23:0], Buffer};
                            r_crc   <= w_crc_next;
                            r_count <= r_count + 3'd1;
                        end
                    end
                end

                ST_HOLD: begin
                    // Bytes arriving here are always dropped; only a lost start byte is flagged.
                    if (w_accept) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_byte_evt && w_is_start) begin
                        r_overrun <= 1'b1;
                    end
                end

                default: begin
                    r_count     <= 3'd0;
                    r_cmd_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign CmdValid = r_cmd_valid;
    assign CmdIndex = r_cmd_index;
    assign CmdArg   = r_cmd_arg;
    assign CrcOk    = r_crc_ok;
    assign Overrun  = r_overrun;

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Directed bench for spi_cmd_framer: two instances (CRC check on/off) share
// stimulus; inputs change and outputs are sampled on the falling clock edge.
module tb_spi_cmd_framer;

    logic        CLK;
    logic        RST_N;
    logic        CS;
    logic [7:0]  Buffer;
    logic        Changed;
    logic        CmdReady;

    logic        CmdValid,   CmdValid_nc;
    logic [5:0]  CmdIndex,   CmdIndex_nc;
    logic [31:0] CmdArg,     CmdArg_nc;
    logic        CrcOk,      CrcOk_nc;
    logic        Overrun,    Overrun_nc;

    int errors = 0;
    int checks = 0;

    spi_cmd_framer #(.CRC_CHECK(1'b1), .FILL_BYTE(8'hFF)) dut (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .Buffer(Buffer), .Changed(Changed),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdIndex(CmdIndex),
        .CmdArg(CmdArg), .CrcOk(CrcOk), .Overrun(Overrun)
    );

    spi_cmd_framer #(.CRC_CHECK(1'b0), .FILL_BYTE(8'hFF)) dut_nc (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .Buffer(Buffer), .Changed(Changed),
        .CmdValid(CmdValid_nc), .CmdReady(CmdReady), .CmdIndex(CmdIndex_nc),
        .CmdArg(CmdArg_nc), .CrcOk(CrcOk_nc), .Overrun(Overrun_nc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        Buffer  = b;
        Changed = 1'b1;
        @(negedge CLK);
        Changed = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f);
        logic [47:0] fr;
        fr = f;
        for (int i = 5; i >= 0; i--) send_byte(fr[i*8 +: 8]);
    endtask

    task automatic accept();
        @(negedge CLK);
        CmdReady = 1'b1;
        @(negedge CLK);
        CmdReady = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"},   {31'd0, CmdValid}, 32'd0);
        check({tag, "_index"},   {26'd0, CmdIndex}, 32'd0);
        check({tag, "_arg"},     CmdArg,            32'd0);
        check({tag, "_crcok"},   {31'd0, CrcOk},    32'd0);
        check({tag, "_overrun"}, {31'd0, Overrun},  32'd0);
    endtask

    initial begin
        RST_N    = 1'b0;
        CS       = 1'b1;
        Buffer   = 8'h00;
        Changed  = 1'b0;
        CmdReady = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        check_cleared("reset");
        RST_N = 1'b1;
        @(negedge CLK);
        CS = 1'b0;

        // CMD0, latency, hold under backpressure, accept
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        check("cmd0_pre_valid", {31'd0, CmdValid}, 32'd0);
        send_byte(8'h95);
        check("cmd0_valid", {31'd0, CmdValid}, 32'd1);
        check("cmd0_index", {26'd0, CmdIndex}, 32'd0);
        check("cmd0_arg",   CmdArg,            32'd0);
        check("cmd0_crcok", {31'd0, CrcOk},    32'd1);
        repeat (3) @(negedge CLK);
        check("cmd0_held",  {31'd0, CmdValid}, 32'd1);
        accept();
        check("cmd0_cleared", {31'd0, CmdValid}, 32'd0);

        // CMD8 preceded by fill bytes
        send_byte(8'hFF); send_byte(8'hFF);
        send_frame(48'h48_00_00_01_AA_87);
        check("cmd8_valid", {31'd0, CmdValid}, 32'd1);
        check("cmd8_index", {26'd0, CmdIndex}, 32'd8);
        check("cmd8_arg",   CmdArg,            32'h0000_01AA);
        check("cmd8_crcok", {31'd0, CrcOk},    32'd1);
        accept();

        // Corrupt CRC: checked instance flags it, unchecked instance does not
        send_frame(48'h40_00_00_00_00_97);
        check("badcrc_valid",    {31'd0, CmdValid},    32'd1);
        check("badcrc_crcok",    {31'd0, CrcOk},       32'd0);
        check("badcrc_nc_valid", {31'd0, CmdValid_nc}, 32'd1);
        check("badcrc_nc_crcok", {31'd0, CrcOk_nc},    32'd1);
        accept();

        // End bit 0 fails with either setting
        send_frame(48'h40_00_00_00_00_94);
        check("endbit_crcok",    {31'd0, CrcOk},    32'd0);
        check("endbit_nc_crcok", {31'd0, CrcOk_nc}, 32'd0);
        accept();

        // Abort mid-frame; a strobe while deselected is ignored
        send_byte(8'h48); send_byte(8'h00); send_byte(8'h00);
        @(negedge CLK);
        CS = 1'b1;
        send_byte(8'h40);
        CS = 1'b0;
        send_frame(48'h40_00_00_00_00_95);
        check("abort_valid", {31'd0, CmdValid}, 32'd1);
        check("abort_index", {26'd0, CmdIndex}, 32'd0);
        check("abort_arg",   CmdArg,            32'd0);
        check("abort_crcok", {31'd0, CrcOk},    32'd1);
        accept();
        repeat (3) @(negedge CLK);
        check("abort_single", {31'd0, CmdValid}, 32'd0);

        // Backpressure: start byte while pending -> one-cycle Overrun
        send_frame(48'h40_00_00_00_00_95);
        send_byte(8'h51);
        check("ovr_pulse",  {31'd0, Overrun},  32'd1);
        check("ovr_index",  {26'd0, CmdIndex}, 32'd0);
        check("ovr_valid",  {31'd0, CmdValid}, 32'd1);
        @(negedge CLK);
        check("ovr_oneshot", {31'd0, Overrun}, 32'd0);
        send_byte(8'h00);
        check("ovr_nonstart", {31'd0, Overrun}, 32'd0);
        // Start byte coinciding with accept: accept wins, no restart, no Overrun
        Buffer   = 8'h51;
        Changed  = 1'b1;
        CmdReady = 1'b1;
        @(negedge CLK);
        Changed  = 1'b0;
        CmdReady = 1'b0;
        check("coinc_overrun", {31'd0, Overrun},  32'd0);
        check("coinc_valid",   {31'd0, CmdValid}, 32'd0);
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        check("coinc_norestart", {31'd0, CmdValid}, 32'd0);

        // Asynchronous reset mid-frame discards the partial CMD8
        send_byte(8'h48); send_byte(8'h00); send_byte(8'h00);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check_cleared("midreset");
        @(negedge CLK);
        RST_N = 1'b1;
        send_frame(48'h40_00_00_00_00_95);
        check("post_reset_valid", {31'd0, CmdValid}, 32'd1);
        check("post_reset_index", {26'd0, CmdIndex}, 32'd0);
        check("post_reset_arg",   CmdArg,            32'd0);
        check("post_reset_crcok", {31'd0, CrcOk},    32'd1);
        accept();
        check("post_reset_clear", {31'd0, CmdValid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
